// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one subtract/shift step per clock.
// Optional macro SEQ_DIVIDER_DIVZERO_FAST_EN: a zero divisor completes in one cycle without iterating.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DZERO
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   pr;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             fast_zero;

  always_comb begin
    pr       = {rem, shreg[WIDTH-1]};
    ge       = (pr >= {1'b0, divisor});
    rem_next = ge ? WIDTH'(pr - {1'b0, divisor}) : pr[WIDTH-1:0];
    quo_next = (shreg << 1) | WIDTH'(ge);
`ifdef SEQ_DIVIDER_DIVZERO_FAST_EN
    fast_zero = (b == '0);
`else
    fast_zero = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      div0    <= 1'b0;
      count   <= '0;
      shreg   <= '0;
      divisor <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shreg   <= a;
            divisor <= b;
            rem     <= '0;
            count   <= '0;
            if (fast_zero) begin
              state <= DZERO;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          shreg <= quo_next;
          rem   <= rem_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= quo_next;
            r     <= rem_next;
            div0  <= (divisor == '0);
          end
        end
        DZERO: begin
          // shreg still holds the captured dividend here
          state <= DONE;
          done  <= 1'b1;
          q     <= '1;
          r     <= shreg;
          div0  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle-level arithmetic model checked every cycle, plus directed literal cases.
module tb_seq_divider;
  localparam int W = 4;
`ifdef SEQ_DIVIDER_DIVZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, div0;

  int passes = 0;
  int total  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: an accepted op finishes a fixed number of cycles later with a/b, a%b.
  int           left = 0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0, p_div0 = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      left = 0; m_busy = 1'b0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_div0 = 1'b0;
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1'b1; m_busy = 1'b0;
          m_q = p_q; m_r = p_r; m_div0 = p_div0;
        end
      end else if (start) begin
        if (b == 0) begin
          p_q = '1; p_r = a; p_div0 = 1'b1;
          left = FAST ? 1 : W;
          m_busy = !FAST;
        end else begin
          p_q = a / b; p_r = a % b; p_div0 = 1'b0;
          left = W;
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (left == 0) begin
        check("q", q, m_q);
        check("r", r, m_r);
        check("div0", div0, m_div0);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        output logic [W-1:0] oq, output logic [W-1:0] orr,
                        output logic od, output int lat);
    @(negedge clk); a = ta; b = tbv; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk); lat++;
    end
    oq = q; orr = r; od = div0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [W-1:0] oq, orr;
    logic         od;
    int           lat, nd;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_q", q, 0); check("rst_r", r, 0); check("rst_div0", div0, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    run_op(4'd11, 4'd3, oq, orr, od, lat);
    check("t1_q", oq, 3); check("t1_r", orr, 2); check("t1_div0", od, 0); check("t1_lat", lat, 4);
    run_op(4'd15, 4'd1, oq, orr, od, lat);
    check("t2a_q", oq, 15); check("t2a_r", orr, 0);
    run_op(4'd0, 4'd5, oq, orr, od, lat);
    check("t2b_q", oq, 0); check("t2b_r", orr, 0); check("t2b_lat", lat, 4);
    run_op(4'd2, 4'd7, oq, orr, od, lat);
    check("t2c_q", oq, 0); check("t2c_r", orr, 2);
    run_op(4'd6, 4'd0, oq, orr, od, lat);
    check("t3_q", oq, 15); check("t3_r", orr, 6); check("t3_div0", od, 1);
    check("t3_lat", lat, FAST ? 1 : 4);

    // start pulsed again while busy must be ignored
    @(negedge clk); a = 4'd9; b = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'd14; b = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (done) nd++;
    end
    check("t4_dones", nd, 1); check("t4_q", q, 4); check("t4_r", r, 1);

    // start held high: back-to-back ops, two done pulses over ten edges
    @(negedge clk); a = 4'd8; b = 4'd3; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (done) nd++;
    end
    start = 1'b0;
    check("t4_held_dones", nd, 2); check("t4_held_q", q, 2); check("t4_held_r", r, 2);

    // reset during the second busy cycle aborts the op
    @(negedge clk); a = 4'd13; b = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0); check("t5_done", done, 0);
    check("t5_q", q, 0); check("t5_r", r, 0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (done) nd++;
    end
    check("t5_no_done", nd, 0);
    run_op(4'd13, 4'd3, oq, orr, od, lat);
    check("t5_q2", oq, 4); check("t5_r2", orr, 1); check("t5_lat", lat, 4);

    // sweep of every non-zero divisor
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        run_op(W'(ia), W'(ib), oq, orr, od, lat);
        check("sweep_identity", int'(oq) * ib + int'(orr), ia);
        check("sweep_rem_lt_b", (int'(orr) < ib) ? 1 : 0, 1);
        check("sweep_lat", lat, 4);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
